// File: rtl/id_ex_if.sv
// Bundles the ID/EX stage's ID-side inputs, forwarding inputs and outputs toward EX.
// The master modport drives the stage; the slave modport is the stage itself.
interface id_ex_if;
   logic        stall;
   logic        flush;
   logic [31:0] id_rd1;
   logic [31:0] id_rd2;
   logic [31:0] id_imm;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic [1:0]  id_alu_op;
   logic [5:0]  id_funct;
   logic        id_alu_src;
   logic        id_reg_dst;
   logic        id_mem_read;
   logic        id_mem_write;
   logic        id_reg_write;
   logic        id_mem_to_reg;
   logic        mem_reg_write;
   logic [4:0]  mem_rd;
   logic [31:0] mem_alu_out;
   logic        wb_reg_write;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_operation;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_dest;
   logic        ex_mem_read;
   logic        ex_mem_write;
   logic        ex_reg_write;
   logic        ex_mem_to_reg;
   logic        load_use_stall;

   modport master (
      output stall, flush, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_alu_op, id_funct,
             id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
             mem_reg_write, mem_rd, mem_alu_out, wb_reg_write, wb_rd, wb_data,
      input  alu_a, alu_b, alu_operation, ex_store_data, ex_dest, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_mem_to_reg, load_use_stall
   );

   modport slave (
      input  stall, flush, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_alu_op, id_funct,
             id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg,
             mem_reg_write, mem_rd, mem_alu_out, wb_reg_write, wb_rd, wb_data,
      output alu_a, alu_b, alu_operation, ex_store_data, ex_dest, ex_mem_read, ex_mem_write,
             ex_reg_write, ex_mem_to_reg, load_use_stall
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-op decode, EX/MEM and MEM/WB operand forwarding
// placed after the register, and load-use hazard detection.
module id_ex_stage (
   input logic     clk,
   input logic     rst,
   id_ex_if.slave  bus
);
   logic [31:0] rd1_r;
   logic [31:0] rd2_r;
   logic [31:0] imm_r;
   logic [4:0]  rs_r;
   logic [4:0]  rt_r;
   logic [4:0]  dest_r;
   logic        alu_src_r;
   logic [2:0]  alu_operation_r;
   logic        mem_read_r;
   logic        mem_write_r;
   logic        reg_write_r;
   logic        mem_to_reg_r;

   logic [2:0]  alu_operation_s;
   logic [4:0]  dest_s;
   logic [31:0] fwd_a_s;
   logic [31:0] fwd_b_s;

   function automatic logic [2:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
      logic [2:0] op;
      op = 3'b010;
      case (alu_op)
         2'b00: op = 3'b010;
         2'b01: op = 3'b110;
         2'b11: op = 3'b111;
         2'b10: begin
            case (funct)
               6'b100000: op = 3'b010;
               6'b100010: op = 3'b110;
               6'b100100: op = 3'b000;
               6'b100101: op = 3'b001;
               6'b101010: op = 3'b111;
               default:   op = 3'b010;
            endcase
         end
         default: op = 3'b010;
      endcase
      return op;
   endfunction

   // EX/MEM beats MEM/WB; writes to $0 are never forwarded.
   function automatic logic [31:0] forward(
      input logic [4:0]  src,
      input logic [31:0] reg_val,
      input logic        m_we,
      input logic [4:0]  m_rd,
      input logic [31:0] m_val,
      input logic        w_we,
      input logic [4:0]  w_rd,
      input logic [31:0] w_val
   );
      logic [31:0] res;
      if (m_we && (m_rd != 5'd0) && (m_rd == src)) begin
         res = m_val;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == src)) begin
         res = w_val;
      end else begin
         res = reg_val;
      end
      return res;
   endfunction

   // Decode ALU operation and destination register ahead of the pipeline register.
   always_comb begin
      alu_operation_s = alu_decode(bus.id_alu_op, bus.id_funct);
      dest_s          = 5'd0;
      if (bus.id_reg_dst) begin
         dest_s = bus.id_rd;
      end else begin
         dest_s = bus.id_rt;
      end
   end

   // Pipeline register: reset, then flush (bubble), then stall (hold), then load.
   always_ff @(posedge clk) begin
      if (!rst || bus.flush) begin
         rd1_r           <= 32'd0;
         rd2_r           <= 32'd0;
         imm_r           <= 32'd0;
         rs_r            <= 5'd0;
         rt_r            <= 5'd0;
         dest_r          <= 5'd0;
         alu_src_r       <= 1'b0;
         alu_operation_r <= 3'b000;
         mem_read_r      <= 1'b0;
         mem_write_r     <= 1'b0;
         reg_write_r     <= 1'b0;
         mem_to_reg_r    <= 1'b0;
      end else if (!bus.stall) begin
         rd1_r           <= bus.id_rd1;
         rd2_r           <= bus.id_rd2;
         imm_r           <= bus.id_imm;
         rs_r            <= bus.id_rs;
         rt_r            <= bus.id_rt;
         dest_r          <= dest_s;
         alu_src_r       <= bus.id_alu_src;
         alu_operation_r <= alu_operation_s;
         mem_read_r      <= bus.id_mem_read;
         mem_write_r     <= bus.id_mem_write;
         reg_write_r     <= bus.id_reg_write;
         mem_to_reg_r    <= bus.id_mem_to_reg;
      end else begin
         rd1_r           <= rd1_r;
         rd2_r           <= rd2_r;
         imm_r           <= imm_r;
         rs_r            <= rs_r;
         rt_r            <= rt_r;
         dest_r          <= dest_r;
         alu_src_r       <= alu_src_r;
         alu_operation_r <= alu_operation_r;
         mem_read_r      <= mem_read_r;
         mem_write_r     <= mem_write_r;
         reg_write_r     <= reg_write_r;
         mem_to_reg_r    <= mem_to_reg_r;
      end
   end

   // Forwarding muxes follow the register so they keep tracking during a stall.
   always_comb begin
      fwd_a_s = forward(rs_r, rd1_r, bus.mem_reg_write, bus.mem_rd, bus.mem_alu_out,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_data);
      fwd_b_s = forward(rt_r, rd2_r, bus.mem_reg_write, bus.mem_rd, bus.mem_alu_out,
                        bus.wb_reg_write, bus.wb_rd, bus.wb_data);
      bus.alu_a         = fwd_a_s;
      bus.ex_store_data = fwd_b_s;
      bus.alu_b         = 32'd0;
      if (alu_src_r) begin
         bus.alu_b = imm_r;
      end else begin
         bus.alu_b = fwd_b_s;
      end
      bus.load_use_stall = mem_read_r && (dest_r != 5'd0) &&
                           ((dest_r == bus.id_rs) || (dest_r == bus.id_rt));
   end

   assign bus.alu_operation = alu_operation_r;
   assign bus.ex_dest       = dest_r;
   assign bus.ex_mem_read   = mem_read_r;
   assign bus.ex_mem_write  = mem_write_r;
   assign bus.ex_reg_write  = reg_write_r;
   assign bus.ex_mem_to_reg = mem_to_reg_r;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed stimulus pushes hand-computed expectations,
// a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_id_ex_stage;
   logic clk;
   logic rst;
   id_ex_if bus ();

   id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sd;
      logic [2:0]  op;
      logic [4:0]  dest;
      logic [3:0]  ctrl;   // {mem_read, mem_write, reg_write, mem_to_reg}
      logic        lus;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   function automatic exp_t mk(string n, logic [31:0] a, logic [31:0] b, logic [31:0] sd,
                               logic [2:0] op, logic [4:0] dest, logic [3:0] ctrl, logic lus);
      exp_t e;
      e.name = n; e.a = a; e.b = b; e.sd = sd; e.op = op; e.dest = dest; e.ctrl = ctrl; e.lus = lus;
      return e;
   endfunction

   task automatic cmp(string n, string f, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got 0x%08h expected 0x%08h", n, f, act, exp);
      end
   endtask

   // Monitor: compare every pending expectation at the falling edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e = q.pop_front();
            cmp(e.name, "alu_a", bus.alu_a, e.a);
            cmp(e.name, "alu_b", bus.alu_b, e.b);
            cmp(e.name, "store", bus.ex_store_data, e.sd);
            cmp(e.name, "alu_op", {29'd0, bus.alu_operation}, {29'd0, e.op});
            cmp(e.name, "dest", {27'd0, bus.ex_dest}, {27'd0, e.dest});
            cmp(e.name, "ctrl", {28'd0, bus.ex_mem_read, bus.ex_mem_write, bus.ex_reg_write,
                                 bus.ex_mem_to_reg}, {28'd0, e.ctrl});
            cmp(e.name, "lus", {31'd0, bus.load_use_stall}, {31'd0, e.lus});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic set_id(logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm, logic [4:0] rs,
                         logic [4:0] rt, logic [4:0] rd, logic [1:0] aop, logic [5:0] fn,
                         logic asrc, logic rdst, logic mr, logic mw, logic rw, logic m2r);
      bus.id_rd1 = rd1; bus.id_rd2 = rd2; bus.id_imm = imm;
      bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
      bus.id_alu_op = aop; bus.id_funct = fn;
      bus.id_alu_src = asrc; bus.id_reg_dst = rdst;
      bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_reg_write = rw; bus.id_mem_to_reg = m2r;
   endtask

   task automatic set_fwd(logic mwe, logic [4:0] mrd, logic [31:0] mval,
                          logic wwe, logic [4:0] wrd, logic [31:0] wval);
      bus.mem_reg_write = mwe; bus.mem_rd = mrd; bus.mem_alu_out = mval;
      bus.wb_reg_write = wwe; bus.wb_rd = wrd; bus.wb_data = wval;
   endtask

   // Inputs change just after a falling edge, so the next rising edge captures them
   // and the following falling edge sees settled outputs.
   task automatic tick();
      @(posedge clk); #1;
      @(negedge clk); #1;
   endtask

   task automatic tick_check(exp_t e);
      @(posedge clk); #1;
      q.push_back(e);
      @(negedge clk); #1;
   endtask

   task automatic decode_case(string n, logic [1:0] aop, logic [5:0] fn, logic [2:0] exp_op);
      set_id(32'h0000_0010, 32'h0000_0020, 32'h0000_0000, 5'd10, 5'd11, 5'd12, aop, fn,
             1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_check(mk(n, 32'h10, 32'h20, 32'h20, exp_op, 5'd12, 4'b0010, 1'b0));
   endtask

   initial begin
      rst = 1'b0;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      set_id(32'd11, 32'd22, 32'd33, 5'd3, 5'd4, 5'd5, 2'b10, 6'b100010,
             1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      tick_check(mk("reset", 32'd0, 32'd0, 32'd0, 3'b000, 5'd0, 4'b0000, 1'b0));

      rst = 1'b1;
      set_id(32'd5, 32'd7, 32'd0, 5'd3, 5'd4, 5'd5, 2'b10, 6'b100000,
             1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_check(mk("add_load", 32'd5, 32'd7, 32'd7, 3'b010, 5'd5, 4'b0010, 1'b0));

      bus.stall = 1'b1;
      set_fwd(1'b1, 5'd3, 32'h0000_AAAA, 1'b1, 5'd3, 32'h0000_BBBB);
      tick_check(mk("fwd_mem_prio", 32'h0000_AAAA, 32'd7, 32'd7, 3'b010, 5'd5, 4'b0010, 1'b0));
      set_fwd(1'b0, 5'd3, 32'h0000_AAAA, 1'b1, 5'd3, 32'h0000_BBBB);
      tick_check(mk("fwd_wb", 32'h0000_BBBB, 32'd7, 32'd7, 3'b010, 5'd5, 4'b0010, 1'b0));
      set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h0000_00CC);
      tick_check(mk("fwd_rt_wb", 32'd5, 32'hCC, 32'hCC, 3'b010, 5'd5, 4'b0010, 1'b0));

      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      for (int i = 0; i < 3; i++) begin
         set_id(32'd100 + i, 32'd200 + i, 32'd300 + i, 5'd20 + 5'(i), 5'd21, 5'd22, 2'b01,
                6'b000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
         tick_check(mk("stall_hold", 32'd5, 32'd7, 32'd7, 3'b010, 5'd5, 4'b0010, 1'b0));
      end

      bus.stall = 1'b0;
      set_id(32'd1, 32'h99, 32'd0, 5'd2, 5'd0, 5'd6, 2'b00, 6'b000000,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_fwd(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0, 32'h5);
      tick_check(mk("reg_zero", 32'd1, 32'h99, 32'h99, 3'b010, 5'd0, 4'b0000, 1'b0));

      set_id(32'h100, 32'h11, 32'hFFFF_FFFC, 5'd1, 5'd7, 5'd0, 2'b00, 6'b000000,
             1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55);
      tick_check(mk("imm_sw", 32'h100, 32'hFFFF_FFFC, 32'h55, 3'b010, 5'd7, 4'b0100, 1'b0));

      set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      set_id(32'd40, 32'd2, 32'd0, 5'd5, 5'd6, 5'd9, 2'b01, 6'b000000,
             1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick_check(mk("sub_load", 32'd40, 32'd2, 32'd2, 3'b110, 5'd9, 4'b0110, 1'b0));
      bus.stall = 1'b1;
      bus.flush = 1'b1;
      tick_check(mk("flush_wins", 32'd0, 32'd0, 32'd0, 3'b000, 5'd0, 4'b0000, 1'b0));

      bus.stall = 1'b0;
      bus.flush = 1'b0;
      set_id(32'h1000, 32'h77, 32'd4, 5'd1, 5'd8, 5'd3, 2'b00, 6'b000000,
             1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      tick_check(mk("lw_load", 32'h1000, 32'd4, 32'h77, 3'b010, 5'd8, 4'b1011, 1'b1));
      bus.stall = 1'b1;
      set_id(32'd0, 32'd0, 32'd0, 5'd8, 5'd2, 5'd0, 2'b00, 6'b000000,
             1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_check(mk("lus_rs", 32'h1000, 32'd4, 32'h77, 3'b010, 5'd8, 4'b1011, 1'b1));
      bus.id_rs = 5'd9; bus.id_rt = 5'd10;
      tick_check(mk("lus_none", 32'h1000, 32'd4, 32'h77, 3'b010, 5'd8, 4'b1011, 1'b0));
      bus.id_rs = 5'd0; bus.id_rt = 5'd8;
      tick_check(mk("lus_rt", 32'h1000, 32'd4, 32'h77, 3'b010, 5'd8, 4'b1011, 1'b1));

      bus.stall = 1'b0;
      decode_case("dec_lwsw", 2'b00, 6'b101010, 3'b010);
      decode_case("dec_beq",  2'b01, 6'b100000, 3'b110);
      decode_case("dec_slti", 2'b11, 6'b100100, 3'b111);
      decode_case("dec_add",  2'b10, 6'b100000, 3'b010);
      decode_case("dec_sub",  2'b10, 6'b100010, 3'b110);
      decode_case("dec_and",  2'b10, 6'b100100, 3'b000);
      decode_case("dec_or",   2'b10, 6'b100101, 3'b001);
      decode_case("dec_slt",  2'b10, 6'b101010, 3'b111);
      decode_case("dec_jr",   2'b10, 6'b001000, 3'b010);
      decode_case("dec_ones", 2'b10, 6'b111111, 3'b010);

      rst = 1'b0;
      bus.stall = 1'b1;
      tick_check(mk("reset_mid", 32'd0, 32'd0, 32'd0, 3'b000, 5'd0, 4'b0000, 1'b0));

      tick();
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register and operand-select stage that feeds the ALU in the five-stage MIPS pipeline. Latches decoded operands and control from ID and decodes the 3-bit ALU operation. Resolves EX/MEM and MEM/WB forwarding to produce the ALU's A and B inputs and the store data, and flags load-use hazards back to the hazard/stall logic.

## Interface
- No parameters. Data width is fixed at 32 bits; register specifiers are fixed at 5 bits.
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- stall  in  1  hold the current contents
- flush  in  1  load a bubble
- id_rd1, id_rd2  in  32  register-file read data for rs and rt
- id_imm  in  32  sign-extended immediate
- id_rs, id_rt, id_rd  in  5  register specifiers
- id_alu_op  in  2  ALU-op class
- id_funct  in  6  instruction funct field
- id_alu_src, id_reg_dst, id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1 each  control bits
- mem_reg_write  in  1  EX/MEM writes a register
- mem_rd  in  5  EX/MEM destination register
- mem_alu_out  in  32  EX/MEM ALU result
- wb_reg_write  in  1  MEM/WB writes a register
- wb_rd  in  5  MEM/WB destination register
- wb_data  in  32  MEM/WB write-back data
- alu_a, alu_b  out  32  ALU operands
- alu_operation  out  3  to the ALU
- ex_store_data  out  32  forwarded rt value, for SW
- ex_dest  out  5  id_rd if reg_dst=1, otherwise id_rt; registered
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1 each  registered control bits
- load_use_stall  out  1  combinational hazard flag

## Operation
- **Registered fields:** rd1, rd2, imm, rs, rt, dest, alu_src, alu_operation, and the four memory/write-back control bits.
- **Update priority at each rising edge of clk:**
  - rst=0: every field is cleared to 0.
  - Otherwise flush=1: bubble (every field 0).
  - Otherwise stall=1: hold.
  - Otherwise: load from ID.
- **ALU-op decode, applied before the register:**
  - id_alu_op 00 → 010 (add).
  - id_alu_op 01 → 110 (sub).
  - id_alu_op 11 → 111 (slt, for slti).
  - id_alu_op 10 decodes id_funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111; any other funct → 010.
- **Forwarding for operand A (registered rs), combinational:**
  - Select mem_alu_out if mem_reg_write=1 and mem_rd≠0 and mem_rd==rs.
  - Otherwise select wb_data if wb_reg_write=1 and wb_rd≠0 and wb_rd==rs.
  - Otherwise select the registered rd1.
  - EX/MEM always has priority over MEM/WB.
- **Forwarding for rt:** same rule as operand A, using rt and rd2. The result drives ex_store_data.
- **alu_b** = the registered imm when alu_src=1, otherwise the forwarded rt value.
- **load_use_stall** = ex_mem_read & (ex_dest≠0) & ((ex_dest==id_rs) | (ex_dest==id_rt)). It is purely combinational from the registered state and the ID inputs.

## Timing
- **Latency:** ID inputs appear on the outputs one cycle after the capturing edge. Forwarding muxes are zero-latency.
- **Reset values:** all registered outputs 0; alu_operation=000; ex_dest=0. With no forwarding hit, alu_a=0, alu_b=0 and ex_store_data=0. load_use_stall is 0 unless the ID inputs match while ex_mem_read=1, which is impossible after reset.
- **Reset mid-operation:** reset overrides flush and stall on the same edge.
- **flush and stall both high:** flush wins.
- **Stall behaviour:** during a stall, outputs still track forwarding-input changes, because the muxes sit after the register.
- **Register $0:** a write targeting register 0 is never forwarded.
- **Load-use stall cycle:** the hazard unit asserts stall on IF/ID and flush here; this block takes no autonomous action.

## Test plan
- **Reset:** rst=0 for 2 cycles with non-zero ID inputs → all outputs 0, alu_operation=000. Release, load add (alu_op=10, funct=100000, rd1=5, rd2=7) → next cycle alu_a=5, alu_b=7, alu_operation=010.
- **Forward priority:** registered rs=3. Drive mem_reg_write=1, mem_rd=3, mem_alu_out=0xAAAA and wb_reg_write=1, wb_rd=3, wb_data=0xBBBB → alu_a=0xAAAA. Drop mem_reg_write → alu_a=0xBBBB.
- **Register zero:** registered rt=0, mem_rd=0, mem_reg_write=1, mem_alu_out=0x1234 → alu_b and ex_store_data stay at the registered rd2.
- **Immediate/SW path:** alu_src=1, imm=0xFFFFFFFC, rt forwarded from WB with 0x55 → alu_b=0xFFFFFFFC, ex_store_data=0x55.
- **Stall/flush precedence:**
  - stall=1 → contents held for 3 cycles while ID inputs change.
  - stall=1 and flush=1 together → bubble: ex_reg_write=0, ex_mem_write=0, alu_operation=000.
- **Load-use and decode sweep:**
  - Registered lw with ex_dest=8 and ex_mem_read=1, ID id_rs=8 → load_use_stall=1. Same case with id_rs=9 and id_rt=10 → 0.
  - Sweep all funct codes, including an unlisted one (001000 → 010).
